// File: rtl/vga_stream_decoder.sv
// VGA sink monitor: recovers pixel coordinates, tile indices and 2-bit RGB from the packed
// pin bus and verifies hsync/vsync timing, asserting locked after consecutive clean frames.
module vga_stream_decoder #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int TILE_SHIFT  = 5,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] vga_in,
   output logic       pix_valid,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic [4:0] tile_x,
   output logic [4:0] tile_y,
   output logic [1:0] pix_r,
   output logic [1:0] pix_g,
   output logic [1:0] pix_b,
   output logic       frame_start,
   output logic       locked,
   output logic       err_hsync,
   output logic       err_vsync
);

   localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_RISE = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_FALL = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_RISE = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_FALL = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
   localparam int         CW     = $clog2(LOCK_FRAMES + 1);

   logic [7:0]    s1;
   logic          hs_prev, vs_prev;
   logic [9:0]    hcnt, vcnt;
   logic          h_synced, v_synced, frame_ok;
   logic [CW-1:0] clean_cnt;

   logic       hs, vs, hs_rise, hs_fall, vs_rise, vs_fall;
   logic       h_err, v_err, any_err, h_wrap, f_wrap, aligned;
   logic [9:0] cur_h, cur_v, nxt_h, nxt_v;

   assign hs      = s1[7];
   assign vs      = s1[3];
   assign hs_rise = hs & ~hs_prev;
   assign hs_fall = ~hs & hs_prev;
   assign vs_rise = vs & ~vs_prev;
   assign vs_fall = ~vs & vs_prev;

   // Edge checks compare against the free-running count; a rise then re-anchors the count.
   // NOTE: each always_comb output gets a default before any condition, so none can infer a latch.
   always_comb begin
      h_err = h_synced & ((hs_rise & (hcnt != H_RISE)) | (hs_fall & (hcnt != H_FALL)));
      v_err = v_synced & ((vs_rise & (vcnt != V_RISE)) | (vs_fall & (vcnt != V_FALL)));
      any_err = h_err | v_err;
      aligned = (h_synced | hs_rise) & (v_synced | vs_rise);

      cur_h = hcnt;
      if (hs_rise) cur_h = H_RISE;
      cur_v = vcnt;
      if (vs_rise) cur_v = V_RISE;

      h_wrap = (cur_h == H_LAST);
      f_wrap = h_wrap & (cur_v == V_LAST);

      nxt_h = cur_h + 10'd1;
      if (h_wrap) nxt_h = '0;
      nxt_v = cur_v;
      if (h_wrap) nxt_v = (cur_v == V_LAST) ? '0 : cur_v + 10'd1;
   end

   // NOTE: state is written with non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1          <= '0;
         hs_prev     <= 1'b0;
         vs_prev     <= 1'b0;
         hcnt        <= '0;
         vcnt        <= '0;
         h_synced    <= 1'b0;
         v_synced    <= 1'b0;
         frame_ok    <= 1'b0;
         clean_cnt   <= '0;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         tile_x      <= '0;
         tile_y      <= '0;
         pix_r       <= '0;
         pix_g       <= '0;
         pix_b       <= '0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         err_hsync   <= 1'b0;
         err_vsync   <= 1'b0;
      end else begin
         s1      <= vga_in;
         hs_prev <= hs;
         vs_prev <= vs;
         hcnt    <= nxt_h;
         vcnt    <= nxt_v;
         if (hs_rise) h_synced <= 1'b1;
         if (vs_rise) v_synced <= 1'b1;

         pix_valid   <= (cur_h < H_VIS) & (cur_v < V_VIS);
         pix_x       <= cur_h;
         pix_y       <= cur_v;
         tile_x      <= 5'(cur_h >> TILE_SHIFT);
         tile_y      <= 5'(cur_v >> TILE_SHIFT);
         pix_r       <= {s1[0], s1[4]};
         pix_g       <= {s1[1], s1[5]};
         pix_b       <= {s1[2], s1[6]};
         frame_start <= locked & ~any_err & (cur_h == '0) & (cur_v == '0);
         err_hsync   <= h_err;
         err_vsync   <= v_err;

         if (any_err) begin
            locked    <= 1'b0;
            clean_cnt <= '0;
            frame_ok  <= 1'b0;
         end
         // A frame only counts if sync was already established when it began.
         if (f_wrap) begin
            frame_ok <= aligned;
            if (frame_ok && !any_err) begin
               if (clean_cnt != CW'(LOCK_FRAMES)) clean_cnt <= clean_cnt + CW'(1);
               if (clean_cnt >= CW'(LOCK_FRAMES - 1)) locked <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_stream_decoder.sv
// Directed bench for vga_stream_decoder on a reduced raster (56x47) so whole frames run quickly;
// a sync generator with fault knobs drives the bus and a probe table checks decoded pixels.
module tb_vga_stream_decoder;

   localparam int HA = 40, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
   localparam int VA = 40, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
   localparam int F  = HT * VT;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] vga_in;
   logic       pix_valid, frame_start, locked, err_hsync, err_vsync;
   logic [9:0] pix_x, pix_y;
   logic [4:0] tile_x, tile_y;
   logic [1:0] pix_r, pix_g, pix_b;

   always #5 clk = ~clk;

   vga_stream_decoder #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .TILE_SHIFT(5), .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .vga_in(vga_in),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .tile_x(tile_x), .tile_y(tile_y),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .frame_start(frame_start), .locked(locked),
      .err_hsync(err_hsync), .err_vsync(err_vsync)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Generator state and fault knobs
   int gx = 0, gy = 0;
   bit gen_syncs = 1'b1;
   bit vlong     = 1'b0;
   int stall_y   = -1;
   int h0x = -1, h0y = -1, h1x = -1, h1y = -1, ox = -1, oy = -1;

   function automatic logic [7:0] encode(input int x, input int y);
      logic       hs, vs;
      logic [1:0] r, g, b;
      hs = gen_syncs && (x >= HA + HF) && (x < HA + HF + HS);
      vs = gen_syncs && (y >= VA + VF) && (y < VA + VF + (vlong ? 3 : 2));
      r  = x[1:0];
      g  = y[1:0];
      b  = x[3:2];
      return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
   endfunction

   // One pixel clock: afterwards (ox,oy) names the sample now visible on the pix_* outputs.
   task automatic step();
      @(posedge clk);
      #1;
      ox  = h1x; oy  = h1y;
      h1x = h0x; h1y = h0y;
      vga_in = encode(gx, gy);
      h0x = gx;  h0y = gy;
      if (stall_y == gy && gx == HA + HF - 1) begin
         stall_y = -1;
      end else begin
         gx++;
         if (gx == HT) begin
            gx = 0;
            gy = (gy == VT - 1) ? 0 : gy + 1;
         end
      end
   endtask

   task automatic wait_locked(input int budget, output int took);
      took = 0;
      while (!locked && took < budget) begin
         step();
         took++;
      end
   endtask

   // Pulse monitor
   int nh = 0, nv = 0, nfs = 0, fs_bad = 0;
   always @(negedge clk) begin
      if (err_hsync) nh++;
      if (err_vsync) nv++;
      if (frame_start) begin
         nfs++;
         if (pix_x != 10'd0 || pix_y != 10'd0 || !pix_valid) fs_bad++;
      end
   end

   typedef struct {
      int x, y;
      int valid, r, g, b, tx, ty;
   } probe_t;
   probe_t probes[7];

   task automatic probe(input int i);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!(ox == probes[i].x && oy == probes[i].y) && k < 2 * F);
      check($sformatf("p%0d_found", i), (ox == probes[i].x && oy == probes[i].y) ? 1 : 0, 1);
      check($sformatf("p%0d_x", i), pix_x, probes[i].x);
      check($sformatf("p%0d_y", i), pix_y, probes[i].y);
      check($sformatf("p%0d_valid", i), pix_valid, probes[i].valid);
      check($sformatf("p%0d_r", i), pix_r, probes[i].r);
      check($sformatf("p%0d_g", i), pix_g, probes[i].g);
      check($sformatf("p%0d_b", i), pix_b, probes[i].b);
      check($sformatf("p%0d_tx", i), tile_x, probes[i].tx);
      check($sformatf("p%0d_ty", i), tile_y, probes[i].ty);
      check($sformatf("p%0d_locked", i), locked, 1);
   endtask

   initial begin
      int took, k, nh0, nv0, bad, ywraps, lk, px, py, ex, ey;

      // colour pattern: r = x[1:0], g = y[1:0], b = x[3:2]
      probes[0] = '{x:0,  y:0,  valid:1, r:0, g:0, b:0, tx:0, ty:0};
      probes[1] = '{x:40, y:10, valid:0, r:0, g:2, b:2, tx:1, ty:0};
      probes[2] = '{x:37, y:35, valid:1, r:1, g:3, b:1, tx:1, ty:1};
      probes[3] = '{x:39, y:39, valid:1, r:3, g:3, b:1, tx:1, ty:1};
      probes[4] = '{x:5,  y:40, valid:0, r:1, g:0, b:1, tx:0, ty:1};
      probes[5] = '{x:46, y:43, valid:0, r:2, g:3, b:3, tx:1, ty:1};
      probes[6] = '{x:55, y:46, valid:0, r:3, g:2, b:1, tx:1, ty:1};

      rst    = 1'b1;
      vga_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", pix_valid, 0);
      check("rst_x", pix_x, 0);
      check("rst_y", pix_y, 0);
      check("rst_locked", locked, 0);
      check("rst_fs", frame_start, 0);
      check("rst_errh", err_hsync, 0);
      check("rst_errv", err_vsync, 0);
      rst = 1'b0;

      // Ideal stream: lock on the wrap that ends the second full clean frame
      wait_locked(4 * F, took);
      check("lock_window", (took >= 3 * F - 2 && took <= 3 * F + 4) ? 1 : 0, 1);
      check("lock_x", pix_x, HT - 1);
      check("lock_y", pix_y, VT - 1);
      for (int i = 0; i < 7; i++) probe(i);

      // One frame_start per frame, always on pixel (0,0)
      k = nfs;
      repeat (F) step();
      check("fs_per_frame", nfs - k, 1);
      check("fs_at_origin", fs_bad, 0);
      check("clean_errh", nh, 0);
      check("clean_errv", nv, 0);

      // Late hsync rise: one error, realign, relock after two clean frames
      nh0 = nh; nv0 = nv;
      stall_y = (gy + 1) % VT;
      k = 0;
      do begin step(); k++; end while (err_hsync !== 1'b1 && k < F);
      check("hshift_err_seen", err_hsync, 1);
      check("hshift_unlock", locked, 0);
      check("hshift_forced_x", pix_x, HA + HF);
      check("hshift_no_errv", err_vsync, 0);
      wait_locked(4 * F, took);
      check("hshift_relock_window", (took >= 2 * F && took <= 3 * F) ? 1 : 0, 1);
      check("hshift_errh_count", nh - nh0, 1);
      check("hshift_errv_count", nv - nv0, 0);
      probe(2);

      // vsync one line too long: error on the late fall only
      nh0 = nh; nv0 = nv;
      vlong = 1'b1;
      k = 0;
      do begin step(); k++; end while (err_vsync !== 1'b1 && k < 2 * F);
      check("vlong_err_seen", err_vsync, 1);
      check("vlong_unlock", locked, 0);
      check("vlong_y", pix_y, VA + VF + 3);
      check("vlong_x", pix_x, 0);
      check("vlong_no_errh", err_hsync, 0);
      vlong = 1'b0;
      repeat (3 * HT) step();
      check("vlong_errv_count", nv - nv0, 1);
      check("vlong_errh_count", nh - nh0, 0);

      // One-cycle reset mid-frame
      k = 0;
      while (!(h0x == 30 && h0y == 20) && k < 2 * F) begin step(); k++; end
      check("rst_mid_found", (h0x == 30 && h0y == 20) ? 1 : 0, 1);
      rst = 1'b1;
      step();
      check("rst_mid_valid", pix_valid, 0);
      check("rst_mid_x", pix_x, 0);
      check("rst_mid_y", pix_y, 0);
      check("rst_mid_tx", tile_x, 0);
      check("rst_mid_r", pix_r, 0);
      check("rst_mid_locked", locked, 0);
      check("rst_mid_fs", frame_start, 0);
      rst = 1'b0;
      nh0 = nh; nv0 = nv;
      wait_locked(4 * F, took);
      check("rst_relock_window", (took >= 2 * F && took <= 3 * F) ? 1 : 0, 1);
      check("rst_resync_errh", nh - nh0, 0);
      check("rst_resync_errv", nv - nv0, 0);

      // No syncs: free-running counters, never locked, never flagged
      gen_syncs = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      nh0 = nh; nv0 = nv;
      step();
      px = pix_x; py = pix_y;
      bad = 0; ywraps = 0; lk = 0;
      for (int i = 0; i < 2 * F; i++) begin
         step();
         ex = (px == HT - 1) ? 0 : px + 1;
         ey = (px == HT - 1) ? ((py == VT - 1) ? 0 : py + 1) : py;
         if (pix_x != 10'(ex) || pix_y != 10'(ey)) bad++;
         if (px == HT - 1 && py == VT - 1) ywraps++;
         if (locked) lk++;
         px = pix_x; py = pix_y;
      end
      check("nosync_count_seq", bad, 0);
      check("nosync_frame_wraps", ywraps, 2);
      check("nosync_locked", lk, 0);
      check("nosync_errh", nh - nh0, 0);
      check("nosync_errv", nv - nv0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
